// File: rtl/sprite_attr_bus_arbiter.sv
// sprite_attr_bus_arbiter
// Two-client arbiter for the shared sprite-attribute bus. For each request it
// enables exactly one sprite register block, waits for the bus to settle,
// captures width/height/animSteps, then returns them with a done pulse.
// A GAP state after every transaction keeps oe all-low for at least one cycle
// between owners, so no two register blocks ever drive the bus together.
//
// Optional build macro: SPRITE_ARB_CACHE_EN adds a one-entry attribute cache
// and the cacheFlush input. A cache hit skips the bus and finishes at T1.
//
// Handshake: a requester raises reqN with a stable idxN and holds it until it
// sees doneN. doneN is a one-cycle pulse, and attr*/idxErr are valid in that
// cycle. attr* then hold their value until the next done.
module sprite_attr_bus_arbiter #(
    parameter int NUM_SPRITES   = 8,
    parameter int IDX_W         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req0,
    input  logic [IDX_W-1:0]       idx0,
    input  logic                   req1,
    input  logic [IDX_W-1:0]       idx1,
    input  logic [5:0]             busWidth,
    input  logic [5:0]             busHeight,
    input  logic [2:0]             busAnimSteps,
`ifdef SPRITE_ARB_CACHE_EN
    input  logic                   cacheFlush,
`endif
    output logic [NUM_SPRITES-1:0] oe,
    output logic                   done0,
    output logic                   done1,
    output logic [5:0]             attrWidth,
    output logic [5:0]             attrHeight,
    output logic [2:0]             attrAnimSteps,
    output logic                   idxErr,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_GAP     = 2'd3
    } state_e;

    // Widened sprite count so an out-of-range index can be detected at any IDX_W.
    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_SPRITES);

    state_e                 state_q;
    logic [2:0]             cnt_q;
    logic                   gnt_id_q;
    logic                   last_gnt_q;
    logic                   err_q;
    logic [NUM_SPRITES-1:0] oe_q;
    logic                   done0_q;
    logic                   done1_q;
    logic                   idx_err_q;
    logic [14:0]            attr_q;

    logic                   pick1;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_err;
    logic [NUM_SPRITES-1:0] sel_oe;
    logic                   cache_hit;

`ifdef SPRITE_ARB_CACHE_EN
    logic                   cache_valid_q;
    logic [IDX_W-1:0]       cache_idx_q;
    logic [14:0]            cache_attr_q;
    logic [IDX_W-1:0]       gnt_idx_q;
`endif

    // Grant decode in IDLE: single requester wins outright, a tie goes to the
    // requester that was not granted last time.
    always_comb begin
        pick1   = req1 && (!req0 || !last_gnt_q);
        sel_idx = pick1 ? idx1 : idx0;
        sel_err = ({1'b0, sel_idx} >= NUM_W);
        sel_oe  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_oe[i] = 1'b1;
            end
        end
`ifdef SPRITE_ARB_CACHE_EN
        cache_hit = cache_valid_q && (sel_idx == cache_idx_q);
`else
        cache_hit = 1'b0;
`endif
    end

    // Transaction FSM with registered oe, done, idxErr and captured attributes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gnt_id_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            oe_q       <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            idx_err_q  <= 1'b0;
            attr_q     <= '0;
`ifdef SPRITE_ARB_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_idx_q   <= '0;
            cache_attr_q  <= '0;
            gnt_idx_q     <= '0;
`endif
        end else begin
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            idx_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt_id_q   <= pick1;
                        last_gnt_q <= pick1;
                        err_q      <= sel_err;
                        cnt_q      <= '0;
`ifdef SPRITE_ARB_CACHE_EN
                        gnt_idx_q  <= sel_idx;
`endif
                        if (cache_hit) begin
                            // Served from the cache: bus untouched, done at T1.
`ifdef SPRITE_ARB_CACHE_EN
                            attr_q  <= cache_attr_q;
`endif
                            done0_q <= !pick1;
                            done1_q <= pick1;
                            state_q <= S_GAP;
                        end else begin
                            // Out-of-range indices match no oe bit, so oe stays 0.
                            oe_q    <= sel_oe;
                            state_q <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == 3'(SETTLE_CYCLES - 1)) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_CAPTURE: begin
                    attr_q    <= err_q ? 15'd0 : {busWidth, busHeight, busAnimSteps};
                    oe_q      <= '0;
                    done0_q   <= !gnt_id_q;
                    done1_q   <= gnt_id_q;
                    idx_err_q <= err_q;
                    state_q   <= S_GAP;
`ifdef SPRITE_ARB_CACHE_EN
                    if (!err_q) begin
                        cache_valid_q <= 1'b1;
                        cache_idx_q   <= gnt_idx_q;
                        cache_attr_q  <= {busWidth, busHeight, busAnimSteps};
                    end
`endif
                end
                default: begin
                    // GAP: oe already low; no grant here, back to IDLE.
                    state_q <= S_IDLE;
                end
            endcase
`ifdef SPRITE_ARB_CACHE_EN
            // Flush overrides a fill in the same cycle.
            if (cacheFlush) begin
                cache_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign oe            = oe_q;
    assign done0         = done0_q;
    assign done1         = done1_q;
    assign idxErr        = idx_err_q;
    assign attrWidth     = attr_q[14:9];
    assign attrHeight    = attr_q[8:3];
    assign attrAnimSteps = attr_q[2:0];
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_attr_bus_arbiter.sv
// Bench for sprite_attr_bus_arbiter (NUM_SPRITES=6 so that out-of-range indices
// can be exercised). Register blocks are modelled by a fixed attribute table;
// the bus floats to all-ones when no block is enabled.
module tb_sprite_attr_bus_arbiter;
  localparam int NSP = 6;
  localparam int IW  = 3;
  localparam int W   = 17;  // {id, err, width, height, animSteps}
`ifdef SPRITE_ARB_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic           clock;
  logic           resetn;
  logic           req0, req1;
  logic [IW-1:0]  idx0, idx1;
  logic [5:0]     busWidth, busHeight;
  logic [2:0]     busAnimSteps;
  logic [NSP-1:0] oe;
  logic           done0, done1;
  logic [5:0]     attrWidth, attrHeight;
  logic [2:0]     attrAnimSteps;
  logic           idxErr, busy;
`ifdef SPRITE_ARB_CACHE_EN
  logic           cacheFlush;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [NSP-1:0] prev_oe = '0;
  bit             cm_valid = 1'b0;
  int             cm_idx = 0;

  sprite_attr_bus_arbiter #(
    .NUM_SPRITES(NSP),
    .IDX_W(IW),
    .SETTLE_CYCLES(1)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .req0(req0),
    .idx0(idx0),
    .req1(req1),
    .idx1(idx1),
    .busWidth(busWidth),
    .busHeight(busHeight),
    .busAnimSteps(busAnimSteps),
`ifdef SPRITE_ARB_CACHE_EN
    .cacheFlush(cacheFlush),
`endif
    .oe(oe),
    .done0(done0),
    .done1(done1),
    .attrWidth(attrWidth),
    .attrHeight(attrHeight),
    .attrAnimSteps(attrAnimSteps),
    .idxErr(idxErr),
    .busy(busy)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // register-block contents {width, height, animSteps}
  function automatic logic [14:0] table_attr(int i);
    case (i)
      0: return {6'd5,  6'd9,  3'd1};
      1: return {6'd33, 6'd7,  3'd6};
      2: return {6'd12, 6'd20, 3'd3};
      3: return {6'd40, 6'd2,  3'd5};
      4: return {6'd17, 6'd63, 3'd7};
      5: return {6'd28, 6'd44, 3'd2};
      default: return 15'd0;
    endcase
  endfunction

  // bus model: the enabled block drives, otherwise the bus floats high
  logic [14:0] bus_val;
  always_comb begin
    bus_val = 15'h7fff;
    for (int i = 0; i < NSP; i++)
      if (oe[i]) bus_val = table_attr(i);
  end
  assign {busWidth, busHeight, busAnimSteps} = bus_val;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard push: t0 is the IDLE cycle in which the request is sampled
  task automatic push_exp(input int id, input int idx, input int t0);
    bit err, hit;
    err = (idx >= NSP);
    hit = CACHE && cm_valid && (cm_idx == idx);
    exp_q.push_back({id[0], err, err ? 15'd0 : table_attr(idx)});
    exp_cyc_q.push_back(t0 + (hit ? 1 : 3));
    if (!err) begin
      cm_valid = 1'b1;
      cm_idx   = idx;
    end
  endtask

  // scoreboard compare + invariants
  always @(negedge clock) begin
    if (resetn) begin
      check_eq("oe_onehot", 32'($onehot0(oe)), 32'd1);
      check_eq("done_excl", 32'(done0 & done1), 32'd0);
      if (prev_oe != '0 && oe != '0) check_eq("oe_owner_gap", 32'(oe), 32'(prev_oe));
      prev_oe = oe;
      if (done0 || done1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 32'({done1, done0}), 32'd0);
        end else begin
          logic [W-1:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_eq("done_result", 32'({done1, idxErr, attrWidth, attrHeight, attrAnimSteps}), 32'(e));
          check_eq("done_cycle", cyc, ec);
        end
      end
    end else begin
      prev_oe = '0;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
`ifdef SPRITE_ARB_CACHE_EN
    cacheFlush = 1'b0;
`endif
    cm_valid = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_oe", 32'(oe), 32'd0);
    check_eq("rst_done", 32'({done1, done0}), 32'd0);
    check_eq("rst_attr", 32'({attrWidth, attrHeight, attrAnimSteps}), 32'd0);
    check_eq("rst_misc", 32'({idxErr, busy}), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_done(input int id);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = (id == 0) ? done0 : done1;
    end
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!seen) check_eq("timeout_done", 32'({done1, done0}), (id == 0) ? 32'd1 : 32'd2);
  endtask

  task automatic hold_req(input int id, input int idx);
    if (id == 0) begin
      req0 = 1'b1;
      idx0 = IW'(idx);
    end else begin
      req1 = 1'b1;
      idx1 = IW'(idx);
    end
    wait_done(id);
  endtask

  initial begin
    int c, n;
    resetn = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    idx0 = '0;   idx1 = '0;
`ifdef SPRITE_ARB_CACHE_EN
    cacheFlush = 1'b0;
`endif

    // single read, latency and oe pattern
    do_reset();
    c = cyc;
    push_exp(0, 2, c);
    req0 = 1'b1; idx0 = 3'd2;
    @(negedge clock);
    check_eq("t1_oe_T1", 32'(oe), 32'b000100);
    check_eq("t1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check_eq("t1_oe_T2", 32'(oe), 32'b000100);
    @(negedge clock);
    check_eq("t1_oe_T3", 32'(oe), 32'd0);
    check_eq("t1_done0_T3", 32'(done0), 32'd1);
    req0 = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("t1_attr_hold", 32'({attrWidth, attrHeight, attrAnimSteps}), 32'({6'd12, 6'd20, 3'd3}));
    check_eq("t1_busy_idle", 32'(busy), 32'd0);

    // simultaneous requests: requester 0 first, then 1
    do_reset();
    c = cyc;
    push_exp(0, 1, c);
    push_exp(1, 5, c + 4);
    fork
      hold_req(0, 1);
      hold_req(1, 5);
      begin
        repeat (3) @(negedge clock);
        check_eq("t2_gap_oe", 32'(oe), 32'd0);
        repeat (2) @(negedge clock);
        check_eq("t2_oe_req1", 32'(oe), 32'b100000);
      end
    join

    // both held continuously: grants alternate 0,1,0,1
    do_reset();
    c = cyc;
    push_exp(0, 0, c);
    push_exp(1, 4, c + 4);
    push_exp(0, 0, c + 8);
    push_exp(1, 4, c + 12);
    req0 = 1'b1; idx0 = 3'd0;
    req1 = 1'b1; idx1 = 3'd4;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clock);
      n += int'(done0) + int'(done1);
    end
    req0 = 1'b0; req1 = 1'b0;
    check_eq("t3_alt_count", n, 4);

    // out-of-range index: oe stays 0, idxErr with zeroed attrs
    do_reset();
    c = cyc;
    push_exp(1, 7, c);
    req1 = 1'b1; idx1 = 3'd7;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      check_eq("t4_oe_zero", 32'(oe), 32'd0);
    end
    req1 = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("t4_attr_hold", 32'({idxErr, attrWidth, attrHeight, attrAnimSteps}), 32'd0);

    // reset during DRIVE aborts; following requests complete normally
    do_reset();
    req0 = 1'b1; idx0 = 3'd3;
    @(negedge clock);
    check_eq("t5_oe_drive", 32'(oe), 32'b001000);
    resetn = 1'b0;
    #1;
    check_eq("t5_abort_oe", 32'(oe), 32'd0);
    req0 = 1'b0;
    cm_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("t5_abort_busy", 32'({done1, done0, busy}), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    // index changed after grant is ignored
    c = cyc;
    push_exp(0, 3, c);
    req0 = 1'b1; idx0 = 3'd3;
    @(negedge clock);
    idx0 = 3'd4;
    wait_done(0);
    // request dropped mid-transaction still completes
    @(negedge clock);
    c = cyc;
    push_exp(1, 1, c);
    req1 = 1'b1; idx1 = 3'd1;
    @(negedge clock);
    req1 = 1'b0;
    wait_done(1);

`ifdef SPRITE_ARB_CACHE_EN
    // cache: miss, hit at T1 with no oe, flush, miss again
    do_reset();
    c = cyc;
    push_exp(0, 3, c);
    hold_req(0, 3);
    @(negedge clock);
    c = cyc;
    push_exp(0, 3, c);
    req0 = 1'b1; idx0 = 3'd3;
    @(negedge clock);
    check_eq("cache_hit_oe", 32'(oe), 32'd0);
    check_eq("cache_hit_done", 32'(done0), 32'd1);
    req0 = 1'b0;
    @(negedge clock);
    cacheFlush = 1'b1;
    @(negedge clock);
    cacheFlush = 1'b0;
    cm_valid = 1'b0;
    c = cyc;
    push_exp(0, 3, c);
    hold_req(0, 3);
`endif

    // random single transactions
    do_reset();
    repeat (12) begin
      int id, idx;
      @(negedge clock);
      id  = $urandom_range(0, 1);
      idx = $urandom_range(0, 7);
      c = cyc;
      push_exp(id, idx, c);
      hold_req(id, idx);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    check_eq("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
